// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a valid/ready byte output and one-cycle framing/overrun pulses.
// Defining UART_RX_MAJORITY_EN replaces single mid-bit sampling with a 2-of-3 vote around mid-bit.
module uart_rx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 104
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_WIDTH - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [CW-1:0] START_LAST = CW'(CLKS_PER_BIT / 2);
`else
  localparam logic [CW-1:0] START_LAST = CW'(CLKS_PER_BIT / 2 - 1);
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t                state;
  logic                  s1;
  logic                  rs;
  logic                  sample;
  logic [CW-1:0]         clk_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;

`ifdef UART_RX_MAJORITY_EN
  // hist holds rs from the two previous cycles, so the vote spans decision-2 .. decision.
  logic [1:0] hist;
  always_ff @(posedge clk) begin
    if (rst) hist <= 2'b11;
    else     hist <= {hist[0], rs};
  end
  assign sample = (hist[1] & hist[0]) | (hist[1] & rs) | (hist[0] & rs);
`else
  assign sample = rs;
`endif

  // Handshake: a byte transfers on any cycle with rx_valid & rx_ready; until then
  // rx_valid stays 1 and rx_data stays stable. A byte finishing on the accept cycle reloads.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1        <= 1'b1;
      rs        <= 1'b1;
      state     <= IDLE;
      clk_cnt   <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      s1        <= rx_in;
      rs        <= s1;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      case (state)
        IDLE: begin
          clk_cnt <= '0;
          bit_cnt <= '0;
          if (!rs) begin
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (clk_cnt == START_LAST) begin
            clk_cnt <= '0;
            if (sample) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= DATA;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            shreg   <= {sample, shreg[DATA_WIDTH-1:1]};
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              state   <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        STOP: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            if (sample) begin
              state <= IDLE;
              busy  <= 1'b0;
              if (!rx_valid || rx_ready) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_HIGH;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          // A line held low (break) must return high before a new start is looked for.
          if (rs) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
